// File: rtl/regfile_write_queue.sv
// Write-back buffer in front of the register file's single write port.
// Holds up to DEPTH pending {reg, data} writes in order, drains one per
// cycle, and forwards the newest pending data on two lookup ports.
//
// Handshake: a request transfers at a rising edge where in_valid && in_ready.
// in_ready depends only on occupancy and reset, never on in_valid. The
// register file side has no ready: rf_write pops the head at the edge unless
// rf_stall is high.
module regfile_write_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       rf_stall,
  output logic                       rf_write,
  output logic [ADDR_W-1:0]          rf_register_no,
  output logic [DATA_W-1:0]          rf_reg_data,
  input  logic [ADDR_W-1:0]          lookup_reg1,
  input  logic [ADDR_W-1:0]          lookup_reg2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
  logic [ADDR_W-1:0] reg_mem_d  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];

  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  fwd_idx;

  // Handshake and drain controls; register 0 completes the handshake but is
  // dropped, and a full queue refuses even when a drain is happening.
  always_comb begin
    in_ready = reset_n && (count_q != CNT_W'(DEPTH));
    rf_write = (count_q != '0) && !rf_stall;
    push     = in_valid && in_ready && (in_reg != '0);
    pop      = rf_write;
  end

  // Head entry presented to the register file, zero when empty.
  always_comb begin
    rf_register_no = '0;
    rf_reg_data    = '0;
    if (count_q != '0) begin
      rf_register_no = reg_mem_q[head_q];
      rf_reg_data    = data_mem_q[head_q];
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    fwd_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if (CNT_W'(k) < count_q) begin
        if ((lookup_reg1 != '0) && (reg_mem_q[fwd_idx] == lookup_reg1)) begin
          hit1      = 1'b1;
          fwd_data1 = data_mem_q[fwd_idx];
        end
        if ((lookup_reg2 != '0) && (reg_mem_q[fwd_idx] == lookup_reg2)) begin
          hit2      = 1'b1;
          fwd_data2 = data_mem_q[fwd_idx];
        end
      end
    end
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    reg_mem_d  = reg_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      reg_mem_d[tail_q]  = in_reg;
      data_mem_d[tail_q] = in_data;
      tail_d             = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every pending write immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      reg_mem_q  <= reg_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a queue model.
module tb_regfile_write_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              rf_stall;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_register_no;
  logic [DATA_W-1:0] rf_reg_data;
  logic [ADDR_W-1:0] lookup_reg1;
  logic [ADDR_W-1:0] lookup_reg2;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
  logic [CNT_W-1:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending writes in acceptance order, {reg, data}.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  regfile_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .rf_stall(rf_stall),
    .rf_write(rf_write), .rf_register_no(rf_register_no),
    .rf_reg_data(rf_reg_data), .lookup_reg1(lookup_reg1),
    .lookup_reg2(lookup_reg2), .hit1(hit1), .hit2(hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One model-checked cycle. Called just after a rising edge; drives the
  // inputs, checks every output at the falling edge against the queue model,
  // then advances the model across the next rising edge.
  task automatic cyc(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                     input logic s, input logic [ADDR_W-1:0] l1, input logic [ADDR_W-1:0] l2,
                     output logic acc, output logic wr, output logic [ADDR_W-1:0] wreg);
    int sz;
    logic e_rdy, e_wr, e_h1, e_h2, do_push;
    logic [ADDR_W-1:0] e_reg;
    logic [DATA_W-1:0] e_dat, e_f1, e_f2;
    in_valid = v; in_reg = r; in_data = d; rf_stall = s;
    lookup_reg1 = l1; lookup_reg2 = l2;
    @(negedge clk);
    sz    = exp_q.size();
    e_rdy = (sz != DEPTH);
    e_wr  = (sz != 0) && !s;
    e_reg = '0; e_dat = '0;
    if (sz != 0) {e_reg, e_dat} = exp_q[0];
    e_h1 = 1'b0; e_f1 = '0; e_h2 = 1'b0; e_f2 = '0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (!e_h1 && l1 != 0 && exp_q[i][ADDR_W+DATA_W-1:DATA_W] == l1) begin
        e_h1 = 1'b1; e_f1 = exp_q[i][DATA_W-1:0];
      end
      if (!e_h2 && l2 != 0 && exp_q[i][ADDR_W+DATA_W-1:DATA_W] == l2) begin
        e_h2 = 1'b1; e_f2 = exp_q[i][DATA_W-1:0];
      end
    end
    chk("m.in_ready", 32'(in_ready), 32'(e_rdy));
    chk("m.rf_write", 32'(rf_write), 32'(e_wr));
    chk("m.rf_register_no", 32'(rf_register_no), 32'(e_reg));
    chk("m.rf_reg_data", rf_reg_data, e_dat);
    chk("m.hit1", 32'(hit1), 32'(e_h1));
    chk("m.fwd_data1", fwd_data1, e_f1);
    chk("m.hit2", 32'(hit2), 32'(e_h2));
    chk("m.fwd_data2", fwd_data2, e_f2);
    chk("m.count", 32'(count), 32'(sz));
    acc  = in_valid && in_ready;
    wr   = rf_write;
    wreg = rf_register_no;
    do_push = v && e_rdy && (r != 0);
    @(posedge clk);
    if (e_wr) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({r, d});
    #1;
  endtask

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
    logic              s;
    logic [ADDR_W-1:0] l1;
    logic [ADDR_W-1:0] l2;
    logic              rdy;
    logic              wr;
    logic [ADDR_W-1:0] rreg;
    logic [DATA_W-1:0] rdat;
    logic              h1;
    logic [DATA_W-1:0] f1;
    logic              h2;
    logic [DATA_W-1:0] f2;
    logic [CNT_W-1:0]  cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic acc, wr, acc5;
    logic [ADDR_W-1:0] wreg;
    int order[5];
    int n_wr, acc_at;

    // Reset block
    reset_n = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
    rf_stall = 1'b0; lookup_reg1 = 5'd1; lookup_reg2 = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.rf_write", 32'(rf_write), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.hit1", 32'(hit1), 32'd0);
    chk("rst.rf_reg_data", rf_reg_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table: one row per cycle, outputs compared before the edge.
    //           v  reg   data          s  l1 l2   rdy wr rreg rdat          h1 f1            h2 f2            cnt
    vecs[0] = '{1, 5'd1, 32'h39CE739E, 0, 1, 2,   1,  0, 0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
    vecs[1] = '{0, 5'd0, 32'h0,        0, 1, 2,   1,  1, 1,   32'h39CE739E, 1, 32'h39CE739E, 0, 32'h0,        1};
    vecs[2] = '{0, 5'd0, 32'h0,        0, 1, 2,   1,  0, 0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
    vecs[3] = '{1, 5'd1, 32'hAAAAAAAA, 1, 1, 2,   1,  0, 0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
    vecs[4] = '{1, 5'd1, 32'hC0000000, 1, 1, 2,   1,  0, 1,   32'hAAAAAAAA, 1, 32'hAAAAAAAA, 0, 32'h0,        1};
    vecs[5] = '{1, 5'd0, 32'hFFFFFFFF, 1, 1, 2,   1,  0, 1,   32'hAAAAAAAA, 1, 32'hC0000000, 0, 32'h0,        2};
    vecs[6] = '{0, 5'd0, 32'h0,        1, 0, 1,   1,  0, 1,   32'hAAAAAAAA, 0, 32'h0,        1, 32'hC0000000, 2};
    vecs[7] = '{0, 5'd0, 32'h0,        0, 1, 0,   1,  1, 1,   32'hAAAAAAAA, 1, 32'hC0000000, 0, 32'h0,        2};
    vecs[8] = '{0, 5'd0, 32'h0,        0, 1, 0,   1,  1, 1,   32'hC0000000, 1, 32'hC0000000, 0, 32'h0,        1};
    vecs[9] = '{0, 5'd0, 32'h0,        0, 1, 0,   1,  0, 0,   32'h0,        0, 32'h0,        0, 32'h0,        0};

    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].v; in_reg = vecs[i].r; in_data = vecs[i].d;
      rf_stall = vecs[i].s; lookup_reg1 = vecs[i].l1; lookup_reg2 = vecs[i].l2;
      @(negedge clk);
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.rf_write", i), 32'(rf_write), 32'(vecs[i].wr));
      chk($sformatf("v%0d.rf_register_no", i), 32'(rf_register_no), 32'(vecs[i].rreg));
      chk($sformatf("v%0d.rf_reg_data", i), rf_reg_data, vecs[i].rdat);
      chk($sformatf("v%0d.hit1", i), 32'(hit1), 32'(vecs[i].h1));
      chk($sformatf("v%0d.fwd_data1", i), fwd_data1, vecs[i].f1);
      chk($sformatf("v%0d.hit2", i), 32'(hit2), 32'(vecs[i].h2));
      chk($sformatf("v%0d.fwd_data2", i), fwd_data2, vecs[i].f2);
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].cnt));
      @(posedge clk);
      #1;
    end

    // Fill while stalled, hold a fifth request, then drain in order.
    for (int k = 1; k <= 4; k++)
      cyc(1'b1, 5'(k), 32'(k * 'h11), 1'b1, 5'd0, 5'd0, acc, wr, wreg);
    chk("full.count", 32'(count), 32'd4);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    repeat (2) cyc(1'b1, 5'd5, 32'h55, 1'b1, 5'd1, 5'd4, acc, wr, wreg);
    order = '{1, 2, 3, 4, 5};
    n_wr = 0; acc5 = 1'b0; acc_at = -1;
    for (int c = 0; c < 10; c++) begin
      cyc(!acc5, 5'd5, 32'h55, 1'b0, 5'd5, 5'd3, acc, wr, wreg);
      if (acc && !acc5) begin
        acc5 = 1'b1; acc_at = c;
      end
      if (wr) begin
        if (n_wr < 5) chk($sformatf("drain.order%0d", n_wr), 32'(wreg), 32'(order[n_wr]));
        n_wr++;
      end
    end
    chk("drain.writes", 32'(n_wr), 32'd5);
    chk("drain.accept_cycle", 32'(acc_at), 32'd1);

    // Push in the same cycle as a drain with two pending entries.
    cyc(1'b1, 5'd2, 32'hA, 1'b1, 5'd7, 5'd2, acc, wr, wreg);
    cyc(1'b1, 5'd3, 32'hB, 1'b1, 5'd7, 5'd2, acc, wr, wreg);
    cyc(1'b1, 5'd7, 32'h5, 1'b0, 5'd7, 5'd2, acc, wr, wreg);
    chk("pp.count", 32'(count), 32'd2);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd3, acc, wr, wreg);
    chk("pp.first", 32'(wreg), 32'd3);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd3, acc, wr, wreg);
    chk("pp.second", 32'(wreg), 32'd7);
    chk("pp.second_wr", 32'(wr), 32'd1);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd3, acc, wr, wreg);

    // Random traffic against the model; small register range to provoke hits.
    for (int c = 0; c < 400; c++)
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          acc, wr, wreg);
    for (int c = 0; c < DEPTH + 2; c++)
      cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2, acc, wr, wreg);

    // Asynchronous reset with pending entries, then no write after release.
    cyc(1'b1, 5'd1, 32'h101, 1'b1, 5'd1, 5'd2, acc, wr, wreg);
    cyc(1'b1, 5'd2, 32'h202, 1'b1, 5'd1, 5'd2, acc, wr, wreg);
    cyc(1'b1, 5'd3, 32'h303, 1'b1, 5'd1, 5'd2, acc, wr, wreg);
    in_valid = 1'b0;
    chk("ar.pre_count", 32'(count), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("ar.count", 32'(count), 32'd0);
    chk("ar.hit1", 32'(hit1), 32'd0);
    chk("ar.hit2", 32'(hit2), 32'd0);
    chk("ar.in_ready", 32'(in_ready), 32'd0);
    chk("ar.rf_register_no", 32'(rf_register_no), 32'd0);
    chk("ar.fwd_data1", fwd_data1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rf_stall = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ar.post_wr%0d", c), 32'(rf_write), 32'd0);
      chk($sformatf("ar.post_count%0d", c), 32'(count), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
